// File: rtl/led_row_scan_if.sv
// Bundle between the upstream stream masker and the LED panel.
// The master side supplies the row latch, row number and brightness.
// The slave side (led_row_scan) drives the panel row address,
// the active-low output enable and the status flags.
interface led_row_scan_if #(
   parameter int ROW_BITS = 4
);
   logic                led_lat;
   logic [5:0]          row_num;
   logic [7:0]          brightness;
   logic [ROW_BITS-1:0] row_addr;
   logic                led_oe;
   logic                frame_done;
   logic                row_err;

   modport master (
      output led_lat, row_num, brightness,
      input  row_addr, led_oe, frame_done, row_err
   );

   modport slave (
      input  led_lat, row_num, brightness,
      output row_addr, led_oe, frame_done, row_err
   );
endinterface

// File: rtl/led_row_scan.sv
// Row-scan and output-enable controller for a multiplexed LED panel.
// Every row change is break-before-make: the panel is blanked, the row
// address switches, the lines settle, and only then is the row lit for a
// brightness-scaled on-time. A new latch restarts the sequence from any state.
module led_row_scan #(
   parameter int ROW_BITS      = 4,
   parameter int NUM_ROWS      = 16,
   parameter int BLANK_CYCLES  = 4,
   parameter int SETTLE_CYCLES = 2,
   parameter int ON_SHIFT      = 2
) (
   input logic           i2s_clk,
   input logic           rst,
   led_row_scan_if.slave bus
);

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // One counter serves blank, settle and on phases, so it must hold the longest.
   localparam int CNT_W = max_int(max_int($clog2(BLANK_CYCLES + 1), $clog2(SETTLE_CYCLES + 1)),
                                  8 + ON_SHIFT);
   localparam logic [6:0] ROW_LIMIT = 7'(NUM_ROWS);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_BLANK  = 3'd1,
      S_SWITCH = 3'd2,
      S_SETTLE = 3'd3,
      S_ON     = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [CNT_W-1:0]    r_cnt;
   logic [CNT_W-1:0]    w_cnt_next;
   logic [ROW_BITS-1:0] r_pend_row;
   logic [ROW_BITS-1:0] w_pend_next;
   logic [ROW_BITS-1:0] r_row_addr;
   logic [ROW_BITS-1:0] w_row_addr_next;
   logic [7:0]          r_bright;
   logic [7:0]          w_bright_next;
   logic                r_led_oe;
   logic                r_frame_done;
   logic                w_frame_done_next;
   logic                r_row_err;
   logic                w_row_err_next;
   logic                w_row_valid;
   logic                w_cnt_last;

   // Full 6-bit row number is range-checked; only the low bits address the panel.
   assign w_row_valid = ({1'b0, bus.row_num} < ROW_LIMIT);
   assign w_cnt_last  = (r_cnt == CNT_W'(1));

   // Next-state logic: a latch overrides whatever phase is in progress.
   always_comb begin
      w_next            = r_state;
      w_cnt_next        = r_cnt;
      w_pend_next       = r_pend_row;
      w_row_addr_next   = r_row_addr;
      w_bright_next     = r_bright;
      w_frame_done_next = 1'b0;
      w_row_err_next    = r_row_err;
      if (bus.led_lat) begin
         if (w_row_valid) begin
            w_pend_next = bus.row_num[ROW_BITS-1:0];
            w_cnt_next  = CNT_W'(BLANK_CYCLES);
            w_next      = S_BLANK;
         end else begin
            w_row_err_next = 1'b1;
            w_cnt_next     = '0;
            w_next         = S_IDLE;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               w_next = S_IDLE;
            end
            S_BLANK: begin
               if (w_cnt_last) begin
                  w_cnt_next = '0;
                  w_next     = S_SWITCH;
               end else begin
                  w_cnt_next = r_cnt - CNT_W'(1);
               end
            end
            S_SWITCH: begin
               // Address moves only here, while the panel is guaranteed dark.
               w_row_addr_next = r_pend_row;
               w_bright_next   = bus.brightness;
               w_cnt_next      = CNT_W'(SETTLE_CYCLES);
               w_next          = S_SETTLE;
            end
            S_SETTLE: begin
               if (w_cnt_last) begin
                  if (r_bright != 8'd0) begin
                     w_cnt_next = CNT_W'(r_bright) << ON_SHIFT;
                     w_next     = S_ON;
                  end else begin
                     w_cnt_next        = '0;
                     w_frame_done_next = 1'b1;
                     w_next            = S_IDLE;
                  end
               end else begin
                  w_cnt_next = r_cnt - CNT_W'(1);
               end
            end
            S_ON: begin
               if (w_cnt_last) begin
                  w_cnt_next        = '0;
                  w_frame_done_next = 1'b1;
                  w_next            = S_IDLE;
               end else begin
                  w_cnt_next = r_cnt - CNT_W'(1);
               end
            end
            default: begin
               w_cnt_next = '0;
               w_next     = S_IDLE;
            end
         endcase
      end
   end

   // State and output registers; led_oe is decoded from the next state so it is low exactly while ON.
   always_ff @(posedge i2s_clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_pend_row   <= '0;
         r_row_addr   <= '0;
         r_bright     <= 8'd0;
         r_led_oe     <= 1'b1;
         r_frame_done <= 1'b0;
         r_row_err    <= 1'b0;
      end else begin
         r_state      <= w_next;
         r_cnt        <= w_cnt_next;
         r_pend_row   <= w_pend_next;
         r_row_addr   <= w_row_addr_next;
         r_bright     <= w_bright_next;
         r_led_oe     <= (w_next != S_ON);
         r_frame_done <= w_frame_done_next;
         r_row_err    <= w_row_err_next;
      end
   end

   assign bus.row_addr   = r_row_addr;
   assign bus.led_oe     = r_led_oe;
   assign bus.frame_done = r_frame_done;
   assign bus.row_err    = r_row_err;

endmodule

// File: tb/tb_led_row_scan.sv
// Self-checking bench for led_row_scan with default parameters.
// Cycle k of a scenario is the k-th clock period after the edge that
// samples the first latch (latch driven during cycle 0). Expected
// per-cycle outputs {row_err, frame_done, led_oe, row_addr} are pushed
// into a scoreboard queue before stimulus and popped at each falling edge.
module tb_led_row_scan;

   logic i2s_clk;
   logic rst;
   int   n_checks;
   int   n_errors;
   logic [3:0] cur_addr;
   logic       cur_err;
   logic [6:0] sb_q[$];

   led_row_scan_if #(.ROW_BITS(4)) bus();

   led_row_scan #(
      .ROW_BITS(4), .NUM_ROWS(16), .BLANK_CYCLES(4), .SETTLE_CYCLES(2), .ON_SHIFT(2)
   ) dut (
      .i2s_clk(i2s_clk),
      .rst    (rst),
      .bus    (bus)
   );

   initial i2s_clk = 1'b0;
   always #5 i2s_clk = ~i2s_clk;

   function automatic logic [6:0] pack(input logic err, input logic fd, input logic oe,
                                       input logic [3:0] addr);
      return {err, fd, oe, addr};
   endfunction

   function automatic logic [6:0] obs();
      return {bus.row_err, bus.frame_done, bus.led_oe, bus.row_addr};
   endfunction

   task automatic test_reset();
      logic [6:0] e;
      logic [6:0] o;
      rst = 1'b1;
      bus.led_lat = 1'b0;
      bus.row_num = 6'd0;
      bus.brightness = 8'd3;
      repeat (2) @(negedge i2s_clk);
      sb_q.push_back(pack(1'b0, 1'b0, 1'b1, 4'd0));
      e = sb_q.pop_front(); o = obs(); n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL reset_hold: got %b expected %b", o, e); end
      rst = 1'b0;
      // invalid row 20 at cycle 0 sets row_err, valid row 5 at cycle 1 -> ON cycles 9..20
      for (int k = 0; k <= 10; k++) begin
         @(negedge i2s_clk);
         if (k == 10) begin
            sb_q.push_back(pack(1'b1, 1'b0, 1'b0, 4'd5));
            e = sb_q.pop_front(); o = obs(); n_checks++;
            if (o !== e) begin n_errors++; $display("FAIL reset_pre_on: got %b expected %b", o, e); end
         end
         bus.led_lat = (k <= 1);
         bus.row_num = (k == 0) ? 6'd20 : 6'd5;
      end
      #2 rst = 1'b1;
      #1;
      sb_q.push_back(pack(1'b0, 1'b0, 1'b1, 4'd0));
      e = sb_q.pop_front(); o = obs(); n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL reset_async: got %b expected %b", o, e); end
      @(negedge i2s_clk);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge i2s_clk);
         sb_q.push_back(pack(1'b0, 1'b0, 1'b1, 4'd0));
         e = sb_q.pop_front(); o = obs(); n_checks++;
         if (o !== e) begin n_errors++; $display("FAIL reset_idle cycle %0d: got %b expected %b", k, o, e); end
      end
      cur_addr = 4'd0;
      cur_err  = 1'b0;
   endtask

   task automatic test_normal();
      logic [6:0] e;
      logic [6:0] o;
      bus.brightness = 8'd3;
      for (int k = 1; k <= 21; k++)
         sb_q.push_back(pack(cur_err, k == 20, !(k >= 8 && k <= 19), (k >= 6) ? 4'd5 : cur_addr));
      for (int k = 0; k <= 21; k++) begin
         @(negedge i2s_clk);
         if (k >= 1) begin
            e = sb_q.pop_front(); o = obs(); n_checks++;
            if (o !== e) begin n_errors++; $display("FAIL normal cycle %0d: got %b expected %b", k, o, e); end
         end
         bus.led_lat = (k == 0);
         bus.row_num = 6'd5;
      end
      cur_addr = 4'd5;
   endtask

   task automatic test_zero_bright();
      logic [6:0] e;
      logic [6:0] o;
      bus.brightness = 8'd0;
      for (int k = 1; k <= 10; k++)
         sb_q.push_back(pack(cur_err, k == 8, 1'b1, (k >= 6) ? 4'd2 : cur_addr));
      for (int k = 0; k <= 10; k++) begin
         @(negedge i2s_clk);
         if (k >= 1) begin
            e = sb_q.pop_front(); o = obs(); n_checks++;
            if (o !== e) begin n_errors++; $display("FAIL zero_bright cycle %0d: got %b expected %b", k, o, e); end
         end
         bus.led_lat = (k == 0);
         bus.row_num = 6'd2;
      end
      cur_addr = 4'd2;
   endtask

   task automatic test_abort();
      logic [6:0] e;
      logic [6:0] o;
      bus.brightness = 8'd3;
      for (int k = 1; k <= 34; k++)
         sb_q.push_back(pack(cur_err, k == 32,
                             !((k >= 8 && k <= 12) || (k >= 20 && k <= 31)),
                             (k >= 18) ? 4'd9 : ((k >= 6) ? 4'd5 : cur_addr)));
      for (int k = 0; k <= 34; k++) begin
         @(negedge i2s_clk);
         if (k >= 1) begin
            e = sb_q.pop_front(); o = obs(); n_checks++;
            if (o !== e) begin n_errors++; $display("FAIL abort cycle %0d: got %b expected %b", k, o, e); end
         end
         bus.led_lat = (k == 0) || (k == 12);
         bus.row_num = (k == 0) ? 6'd5 : 6'd9;
      end
      cur_addr = 4'd9;
   endtask

   task automatic test_last_on();
      logic [6:0] e;
      logic [6:0] o;
      bus.brightness = 8'd1;
      // on-time 4: ON 8..11, latch in last ON cycle 11 aborts, new ON 19..22
      for (int k = 1; k <= 25; k++)
         sb_q.push_back(pack(cur_err, k == 23,
                             !((k >= 8 && k <= 11) || (k >= 19 && k <= 22)),
                             (k >= 17) ? 4'd8 : ((k >= 6) ? 4'd7 : cur_addr)));
      for (int k = 0; k <= 25; k++) begin
         @(negedge i2s_clk);
         if (k >= 1) begin
            e = sb_q.pop_front(); o = obs(); n_checks++;
            if (o !== e) begin n_errors++; $display("FAIL last_on cycle %0d: got %b expected %b", k, o, e); end
         end
         bus.led_lat = (k == 0) || (k == 11);
         bus.row_num = (k == 0) ? 6'd7 : 6'd8;
      end
      cur_addr = 4'd8;
   endtask

   task automatic test_invalid();
      logic [6:0] e;
      logic [6:0] o;
      bus.brightness = 8'd3;
      // rows 20 and 16 are invalid; row 1 at cycle 5 runs a normal sequence
      for (int k = 1; k <= 27; k++)
         sb_q.push_back(pack(1'b1, k == 25, !(k >= 13 && k <= 24), (k >= 11) ? 4'd1 : cur_addr));
      for (int k = 0; k <= 27; k++) begin
         @(negedge i2s_clk);
         if (k >= 1) begin
            e = sb_q.pop_front(); o = obs(); n_checks++;
            if (o !== e) begin n_errors++; $display("FAIL invalid cycle %0d: got %b expected %b", k, o, e); end
         end
         bus.led_lat = (k == 0) || (k == 2) || (k == 5);
         bus.row_num = (k == 0) ? 6'd20 : ((k == 2) ? 6'd16 : 6'd1);
      end
      cur_addr = 4'd1;
      cur_err  = 1'b1;
   endtask

   task automatic test_back_to_back();
      logic [6:0] e;
      logic [6:0] o;
      bus.brightness = 8'd0;
      // latches of rows 3..12 on cycles 0..9; only row 12 reaches the address at cycle 15
      for (int k = 1; k <= 19; k++)
         sb_q.push_back(pack(cur_err, k == 17, 1'b1, (k >= 15) ? 4'd12 : cur_addr));
      for (int k = 0; k <= 19; k++) begin
         @(negedge i2s_clk);
         if (k >= 1) begin
            e = sb_q.pop_front(); o = obs(); n_checks++;
            if (o !== e) begin n_errors++; $display("FAIL back_to_back cycle %0d: got %b expected %b", k, o, e); end
         end
         bus.led_lat = (k <= 9);
         bus.row_num = 6'(3 + k);
      end
      cur_addr = 4'd12;
   endtask

   task automatic test_max_bright();
      logic [6:0] e;
      logic [6:0] o;
      bus.brightness = 8'd255;
      // 255 << 2 = 1020 ON cycles: 8..1027, frame_done at 1028
      for (int k = 1; k <= 1030; k++)
         sb_q.push_back(pack(cur_err, k == 1028, !(k >= 8 && k <= 1027), (k >= 6) ? 4'd15 : cur_addr));
      for (int k = 0; k <= 1030; k++) begin
         @(negedge i2s_clk);
         if (k >= 1) begin
            e = sb_q.pop_front(); o = obs(); n_checks++;
            if (o !== e) begin n_errors++; $display("FAIL max_bright cycle %0d: got %b expected %b", k, o, e); end
         end
         bus.led_lat = (k == 0);
         bus.row_num = 6'd15;
      end
      cur_addr = 4'd15;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      cur_addr = 4'd0;
      cur_err  = 1'b0;
      rst = 1'b1;
      bus.led_lat = 1'b0;
      bus.row_num = 6'd0;
      bus.brightness = 8'd0;
      test_reset();
      test_normal();
      test_zero_bright();
      test_abort();
      test_last_on();
      test_invalid();
      test_back_to_back();
      test_max_bright();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
